// File: rtl/vram_text_writer_if.sv
// rtl/vram_text_writer_if.sv - byte stream in, video RAM write port and cursor status out
interface vram_text_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic        busy;
  logic [6:0]  cursor_row;
  logic [6:0]  cursor_col;

  modport master (
    input  in_data, in_valid,
    output in_ready, ram_addr, ram_din, ram_we, busy, cursor_row, cursor_col
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, ram_addr, ram_din, ram_we, busy, cursor_row, cursor_col
  );
endinterface

// File: rtl/vram_text_writer.sv
// rtl/vram_text_writer.sv - turns an ASCII byte stream into digit-cell writes on a text-mode video RAM
module vram_text_writer #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 60,
  parameter logic [7:0]  BLANK = 8'h0A
) (
  input  logic               clk,
  input  logic               reset,
  vram_text_writer_if.master bus
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [6:0]  clr_row, clr_row_n;
  logic [6:0]  clr_col, clr_col_n;
  logic        clr_done, clr_done_n;
  logic [6:0]  cur_row, cur_row_n;
  logic [6:0]  cur_col, cur_col_n;
  logic [13:0] addr_q, addr_n;
  logic [7:0]  din_q, din_n;
  logic        we_q, we_n;
  logic        ready_q, ready_n;
  logic        busy_q;
  logic        accept;

  assign accept = bus.in_valid && ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CLEAR;
      clr_row  <= 7'd0;
      clr_col  <= 7'd0;
      clr_done <= 1'b0;
      cur_row  <= 7'd0;
      cur_col  <= 7'd0;
      addr_q   <= 14'd0;
      din_q    <= 8'd0;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state    <= state_n;
      clr_row  <= clr_row_n;
      clr_col  <= clr_col_n;
      clr_done <= clr_done_n;
      cur_row  <= cur_row_n;
      cur_col  <= cur_col_n;
      addr_q   <= addr_n;
      din_q    <= din_n;
      we_q     <= we_n;
      ready_q  <= ready_n;
      busy_q   <= !ready_n;
    end
  end

  always_comb begin
    state_n    = state;
    clr_row_n  = clr_row;
    clr_col_n  = clr_col;
    clr_done_n = clr_done;
    cur_row_n  = cur_row;
    cur_col_n  = cur_col;
    addr_n     = addr_q;
    din_n      = din_q;
    we_n       = 1'b0;

    case (state)
      CLEAR: begin
        // clr_done marks that the last cell went out; one quiet cycle follows before IDLE
        if (clr_done) begin
          state_n = IDLE;
        end else begin
          we_n   = 1'b1;
          addr_n = {clr_row, clr_col};
          din_n  = BLANK;
          if (clr_col == LAST_COL) begin
            clr_col_n = 7'd0;
            if (clr_row == LAST_ROW) begin
              clr_row_n  = 7'd0;
              clr_done_n = 1'b1;
            end else begin
              clr_row_n = clr_row + 7'd1;
            end
          end else begin
            clr_col_n = clr_col + 7'd1;
          end
        end
      end

      IDLE: begin
        if (accept) begin
          if (bus.in_data >= 8'h30 && bus.in_data <= 8'h39) begin
            state_n = WRITE;
            we_n    = 1'b1;
            addr_n  = {cur_row, cur_col};
            din_n   = bus.in_data - 8'h30;
          end else if (bus.in_data == 8'h20) begin
            state_n = WRITE;
            we_n    = 1'b1;
            addr_n  = {cur_row, cur_col};
            din_n   = BLANK;
          end else if (bus.in_data == 8'h0D) begin
            cur_col_n = 7'd0;
          end else if (bus.in_data == 8'h0A) begin
            cur_col_n = 7'd0;
            cur_row_n = (cur_row == LAST_ROW) ? 7'd0 : cur_row + 7'd1;
          end else if (bus.in_data == 8'h0C) begin
            state_n    = CLEAR;
            clr_row_n  = 7'd0;
            clr_col_n  = 7'd0;
            clr_done_n = 1'b0;
            cur_row_n  = 7'd0;
            cur_col_n  = 7'd0;
          end
        end
      end

      WRITE: begin
        state_n = IDLE;
        // cursor wraps from the bottom-right cell to home; the screen never scrolls
        if (cur_col == LAST_COL) begin
          cur_col_n = 7'd0;
          cur_row_n = (cur_row == LAST_ROW) ? 7'd0 : cur_row + 7'd1;
        end else begin
          cur_col_n = cur_col + 7'd1;
        end
      end

      default: begin
        state_n    = CLEAR;
        clr_row_n  = 7'd0;
        clr_col_n  = 7'd0;
        clr_done_n = 1'b0;
      end
    endcase

    ready_n = (state_n == IDLE);
  end

  assign bus.in_ready   = ready_q;
  assign bus.busy       = busy_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_din    = din_q;
  assign bus.ram_we     = we_q;
  assign bus.cursor_row = cur_row;
  assign bus.cursor_col = cur_col;

endmodule
